mux_scan_sampler: RTL and testbench

- Sequencer directly upstream/around the MUX41_D 4:1 bit mux.
- Drives the mux select through channels 0..3 and waits a programmable settle time per channel.
- Samples the mux output for each channel and publishes the 4-bit result with a done pulse and a change flag.
- Replaces software polling of the four mux inputs; supports single-shot and continuous scanning.

---
 rtl/mux_scan_sampler_pkg.sv | 14 +
 rtl/MUX41_D.sv | 11 +
 rtl/mux_scan_sampler_settle_counter.sv | 38 +++
 rtl/mux_scan_sampler.sv | 130 +++++++++++++
 tb/tb_mux_scan_sampler.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_sampler_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
package mux_scan_sampler_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/MUX41_D.sv
// Combinational 4:1 bit mux sitting downstream of the scan sequencer's select.
// Zero latency; no flow control.
module MUX41_D (
  input  logic [3:0] in,
  input  logic [1:0] sel,
  output logic       out
);

  assign out = in[sel];

endmodule

// File: rtl/mux_scan_sampler_settle_counter.sv
// Per-channel settle down-counter: load wins over decrement, holds at zero.
// zero_o reflects the registered count (no same-cycle bypass).
module mux_scan_sampler_settle_counter
  import mux_scan_sampler_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_sampler.sv
// Steps the mux select through all channels, settles, samples, and publishes a 4-bit word.
// A scan takes 4*(SETTLE_CYCLES+1) clocks; start is ignored while busy, nothing is queued.
module mux_scan_sampler
  import mux_scan_sampler_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int          CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont,
  input  logic              mux_out,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] sample,
  output logic              changed
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                changed_q, changed_d;
  logic [NUM_CH-1:0]   sample_q, sample_d;
  logic [NUM_CH-2:0]   staging_q, staging_d;

  logic                cnt_load;
  logic                cnt_dec;
  logic                cnt_zero;
  logic [NUM_CH-1:0]   scan_word;

  mux_scan_sampler_settle_counter #(
    .CNT_W (CNT_W)
  ) u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (SETTLE_LD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // The last channel bypasses staging and goes straight into the published word.
  assign scan_word = {mux_out, staging_q};

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    changed_d = 1'b0;
    sample_d  = sample_q;
    staging_d = staging_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel_d    = '0;
          busy_d   = 1'b1;
          cnt_load = 1'b1;
          state_d  = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (sel_q != LAST_CH) begin
          for (int i = 0; i < NUM_CH - 1; i++) begin
            if (sel_q == SEL_W'(i)) begin
              staging_d[i] = mux_out;
            end
          end
          sel_d    = sel_q + SEL_W'(1);
          cnt_load = 1'b1;
        end else begin
          sample_d  = scan_word;
          done_d    = 1'b1;
          changed_d = (scan_word != sample_q);
          sel_d     = '0;
          if (cont) begin
            cnt_load = 1'b1;
          end else begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      changed_q <= 1'b0;
      sample_q  <= '0;
      staging_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      changed_q <= changed_d;
      sample_q  <= sample_d;
      staging_q <= staging_d;
    end
  end

  assign sel     = sel_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sample  = sample_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Directed bench for mux_scan_sampler: one instance with 2 settle cycles, one with none.
module tb_mux_scan_sampler;

  logic       clk;
  logic       rst_n;

  logic       start2, cont2, mux_out2;
  logic [1:0] sel2;
  logic       busy2, done2, changed2;
  logic [3:0] sample2, in2;

  logic       start0, cont0, mux_out0;
  logic [1:0] sel0;
  logic       busy0, done0, changed0;
  logic [3:0] sample0, in0;

  int n_checks = 0;
  int n_err    = 0;
  int edge_cnt = 0;

  mux_scan_sampler #(.SETTLE_CYCLES(2), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .cont(cont2), .mux_out(mux_out2),
    .sel(sel2), .busy(busy2), .done(done2), .sample(sample2), .changed(changed2)
  );
  MUX41_D u_mux2 (.in(in2), .sel(sel2), .out(mux_out2));

  mux_scan_sampler #(.SETTLE_CYCLES(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cont(cont0), .mux_out(mux_out0),
    .sel(sel0), .busy(busy0), .done(done0), .sample(sample0), .changed(changed0)
  );
  MUX41_D u_mux0 (.in(in0), .sel(sel0), .out(mux_out0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [3:0] in_val;
    logic [3:0] exp_sample;
    logic       exp_changed;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Single-shot scan on the 2-settle instance, with start sampled at relative edge 0.
  task automatic run_scan2(input logic [3:0] v, input logic [3:0] exp_s,
                           input logic exp_c, input string tag);
    int t0, n, es, done_at, seq_bad;
    bit got;
    @(negedge clk);
    in2    = v;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2  = 1'b0;
    t0      = edge_cnt;
    got     = 1'b0;
    done_at = -1;
    seq_bad = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      n  = edge_cnt - t0;
      es = (n >= 12) ? 0 : n / 3;
      if (sel2 !== es[1:0]) seq_bad++;
      if (n < 12 && (busy2 !== 1'b1 || done2 !== 1'b0)) seq_bad++;
      if (done2) begin
        got     = 1'b1;
        done_at = n;
        check({tag, " sample"}, 32'(sample2), 32'(exp_s));
        check({tag, " changed"}, 32'(changed2), 32'(exp_c));
        check({tag, " busy_fall"}, 32'(busy2), 32'd0);
      end
    end
    check({tag, " done_edge"}, done_at, 32'd12);
    check({tag, " sel_sequence"}, seq_bad, 32'd0);
    @(negedge clk);
    check({tag, " done_width"}, 32'({done2, changed2}), 32'd0);
  endtask

  task automatic wait_done0(input int t0, output int at);
    at = -1;
    for (int i = 0; i < 20 && at < 0; i++) begin
      @(negedge clk);
      if (done0) at = edge_cnt - t0;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int t0, at, dones, done_at, n;

    vecs[0] = '{4'b1010, 4'b1010, 1'b1};
    vecs[1] = '{4'b1010, 4'b1010, 1'b0};
    vecs[2] = '{4'b1111, 4'b1111, 1'b1};
    vecs[3] = '{4'b0000, 4'b0000, 1'b1};
    vecs[4] = '{4'b0100, 4'b0100, 1'b1};
    vecs[5] = '{4'b0001, 4'b0001, 1'b1};
    vecs[6] = '{4'b0010, 4'b0010, 1'b1};
    vecs[7] = '{4'b1000, 4'b1000, 1'b1};
    vecs[8] = '{4'b1000, 4'b1000, 1'b0};

    rst_n  = 1'b0;
    start2 = 1'b0; cont2 = 1'b0; in2 = 4'h0;
    start0 = 1'b0; cont0 = 1'b0; in0 = 4'h0;
    #2;
    check("reset dut2 outputs", 32'({sel2, busy2, done2, sample2, changed2}), 32'd0);
    check("reset dut0 outputs", 32'({sel0, busy0, done0, sample0, changed0}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle after reset", 32'({busy2, done2, busy0, done0}), 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_scan2(vecs[i].in_val, vecs[i].exp_sample, vecs[i].exp_changed,
                $sformatf("vec%0d", i));
    end

    // Stray starts at edges 1 and 5 must be dropped, not queued.
    @(negedge clk);
    in2    = 4'b0110;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2  = 1'b0;
    t0      = edge_cnt;
    dones   = 0;
    done_at = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n = edge_cnt - t0;
      if (done2) begin
        dones++;
        if (done_at < 0) done_at = n;
      end
      start2 = (n == 0 || n == 4);
    end
    start2 = 1'b0;
    check("busy_start done count", dones, 32'd1);
    check("busy_start done edge", done_at, 32'd12);
    check("busy_start idle", 32'(busy2), 32'd0);
    check("busy_start sample", 32'(sample2), 32'h6);

    // Asynchronous reset part-way through a scan.
    @(negedge clk);
    in2    = 4'b1001;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset outputs", 32'({sel2, busy2, done2, sample2, changed2}), 32'd0);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done2 || busy2) dones++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done2 || busy2) dones++;
    end
    check("reset abort no activity", dones, 32'd0);
    run_scan2(4'b0100, 4'b0100, 1'b1, "post_reset");

    // Continuous scanning with no settle time.
    @(negedge clk);
    in0    = 4'b0001;
    cont0  = 1'b1;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    t0     = edge_cnt;
    wait_done0(t0, at);
    check("cont scan1 edge", at, 32'd4);
    check("cont scan1 result", 32'({sample0, changed0, busy0}), 32'({4'b0001, 1'b1, 1'b1}));
    in0 = 4'b0110;
    wait_done0(t0, at);
    check("cont scan2 edge", at, 32'd8);
    check("cont scan2 result", 32'({sample0, changed0, busy0}), 32'({4'b0110, 1'b1, 1'b1}));
    wait_done0(t0, at);
    check("cont scan3 edge", at, 32'd12);
    check("cont scan3 result", 32'({sample0, changed0, busy0}), 32'({4'b0110, 1'b0, 1'b1}));
    @(negedge clk);
    cont0 = 1'b0;
    wait_done0(t0, at);
    check("cont drop edge", at, 32'd16);
    check("cont drop result", 32'({sample0, changed0, busy0}), 32'({4'b0110, 1'b0, 1'b0}));
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done0 || busy0) dones++;
    end
    check("cont drop stays idle", dones, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
